// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared state encoding and operator/FP16 constants for the
//            calculator sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        LATCH_A = 3'd1,
        ENTER_B = 3'd2,
        LATCH_B = 3'd3,
        EXEC    = 3'd4,
        CAPTURE = 3'd5,
        SHOW    = 3'd6,
        RESTART = 3'd7
    } calc_state_t;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;
    localparam logic [1:0] OP_DIV = 2'b00;

    localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

endpackage
`default_nettype wire

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer_if
// Brief    : Button/operand-register/LCD side signals of the calculator
//            sequencer; master = sequencer, slave = datapath and board.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_sequencer_if;

    logic        enter_btn;
    logic        clear_btn;
    logic [1:0]  op_sel;
    logic [15:0] result;
    logic        load_a;
    logic        load_b;
    logic        load_c;
    logic        entry_clr;
    logic [1:0]  operation;
    logic        busy;
    logic        result_err;
    logic [2:0]  state_o;

    modport master (
        input  enter_btn, clear_btn, op_sel, result,
        output load_a, load_b, load_c, entry_clr, operation, busy,
               result_err, state_o
    );

    modport slave (
        output enter_btn, clear_btn, op_sel, result,
        input  load_a, load_b, load_c, entry_clr, operation, busy,
               result_err, state_o
    );

endinterface
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_edge_sync
// Brief    : Multi-stage synchroniser for a raw push button followed by a
//            rising-edge detector producing a single-cycle press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Combinational so the FSM acts on the press one edge after the last sync stage.
    assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Brief    : Sequences operand A/B entry, FP settle wait, result capture and
//            display for the calculator datapath.
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    calc_sequencer_if.master bus
);

    localparam int                  c_cnt_w    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_init = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    calc_state_t          r_state;
    calc_state_t          w_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_enter;
    logic                 w_clear;
    logic                 r_load_a;
    logic                 r_load_b;
    logic                 r_load_c;
    logic                 r_entry_clr;
    logic                 r_busy;
    logic                 r_result_err;
    logic [1:0]           r_operation;
    logic                 w_unused_result;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (bus.enter_btn),
        .o_pulse (w_enter)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clear_sync (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (bus.clear_btn),
        .o_pulse (w_clear)
    );

    // Clear aborts from any state and wins over a coincident enter.
    always_comb begin
        w_next = r_state;
        if (w_clear) begin
            w_next = RESTART;
        end else begin
            case (r_state)
                ENTER_A: if (w_enter) w_next = LATCH_A;
                LATCH_A: w_next = ENTER_B;
                ENTER_B: if (w_enter) w_next = LATCH_B;
                LATCH_B: w_next = EXEC;
                EXEC:    if (r_cnt == '0) w_next = CAPTURE;
                CAPTURE: w_next = SHOW;
                SHOW:    if (w_enter) w_next = RESTART;
                RESTART: w_next = ENTER_A;
                default: w_next = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ENTER_A;
            r_cnt       <= '0;
            r_load_a    <= 1'b0;
            r_load_b    <= 1'b0;
            r_load_c    <= 1'b0;
            r_entry_clr <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Strobes are decoded from the next state so they align with it.
            r_load_a    <= (w_next == LATCH_A);
            r_load_b    <= (w_next == LATCH_B);
            r_load_c    <= (w_next == CAPTURE);
            r_entry_clr <= (w_next == LATCH_A) || (w_next == LATCH_B) ||
                           (w_next == RESTART);
            r_busy      <= (w_next == EXEC) || (w_next == CAPTURE);
            if (r_state == LATCH_B) begin
                r_cnt <= c_cnt_init;
            end else if ((r_state == EXEC) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    // Sampled in the cycle load_c is high, i.e. the same value register C captures.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_operation  <= OP_ADD;
            r_result_err <= 1'b0;
        end else begin
            if (r_state == LATCH_A) begin
                r_operation <= bus.op_sel;
            end
            if (r_state == CAPTURE) begin
                r_result_err <= (bus.result[14:10] == FP16_EXP_MAX);
            end else if (r_state == RESTART) begin
                r_result_err <= 1'b0;
            end
        end
    end

    assign w_unused_result = ^{bus.result[15], bus.result[9:0]};

    assign bus.load_a     = r_load_a;
    assign bus.load_b     = r_load_b;
    assign bus.load_c     = r_load_c;
    assign bus.entry_clr  = r_entry_clr;
    assign bus.operation  = r_operation;
    assign bus.busy       = r_busy;
    assign bus.result_err = r_result_err;
    assign bus.state_o    = r_state;

endmodule
`default_nettype wire
